// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready pipeline register with bubble collapse, stall and flush.
// Define PIPE_REG_OCC_EN to add the occ occupancy counter output.
module pipe_reg_elastic #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH+1];
  logic [DEPTH:0]   adv;
  logic [DEPTH:0]   src_v;
  assign src_v = {vld_q, in_valid};
  // adv[DEPTH] stands in for the consumer so the backward chain needs no special case
  always_comb begin
    adv[DEPTH] = out_ready;
    src_d[0] = in_data;
    for (int i = DEPTH - 1; i >= 0; i--) adv[i] = ena & (~vld_q[i] | adv[i+1]);
    for (int i = 0; i < DEPTH; i++) begin
      src_d[i+1] = dat_q[i];
      vld_d[i] = flush ? 1'b0 : (adv[i] ? src_v[i] : vld_q[i]);
      dat_d[i] = (adv[i] & src_v[i] & ~flush) ? src_d[i] : dat_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  assign in_ready  = rst & ~flush & adv[0];
  assign out_valid = vld_q[DEPTH-1] & ena & ~flush;
  assign out_data  = dat_q[DEPTH-1];
`ifdef PIPE_REG_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] ONE = OW'(1);
  logic [OW-1:0] occ_q, occ_d;
  logic in_x, out_x;
  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;
  always_comb begin
    occ_d = flush ? '0 : (in_x & ~out_x) ? occ_q + ONE : (out_x & ~in_x) ? occ_q - ONE : occ_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign occ = occ_q;
`endif
endmodule
